board_draw_sequencer: RTL and testbench
=======================================

# board_draw_sequencer

Initiator for the 8x8 sprite drawer: walks the level tile map and issues one sprite-draw request per tile, paced so the drawer's 64-pixel plot completes before the next request. A full-board redraw is started by a pulse. Single-tile redraws are queued in a small FIFO. It sits between the game logic and the tile-map RAM on one side and the sprite drawer's x/y/sprite/go inputs on the other.

## Interface
- COLS, 20, board width in tiles (160 px / 8)
- ROWS, 15, board height in tiles (120 px / 8)
- SLOT_CYCLES, 66, cycles reserved per draw request, counted from the draw_go cycle
- FIFO_DEPTH, 4, single-tile update queue depth (power of two)

- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- full_start  in  1  one-cycle pulse; request a redraw of the whole board
- upd_valid  in  1  single-tile update request; enqueued when upd_valid && upd_ready
- upd_col  in  5  tile column of update
- upd_row  in  4  tile row of update
- upd_ready  out  1  FIFO not full (combinational)
- map_addr  out  9  tile-map RAM read address = row*COLS + col
- map_data  in  3  sprite id from tile-map RAM; synchronous read, 1-cycle latency
- draw_x  out  8  sprite anchor x = col*8
- draw_y  out  7  sprite anchor y = row*8
- draw_sprite  out  3  sprite id for drawer
- draw_go  out  1  one-cycle go pulse to drawer
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse when a full redraw finishes

## Operation
- States: IDLE, FETCH, WAIT_RAM, GO, HOLD.
- IDLE behaviour:
  - If full redraw is pending, set col=0, row=0, mode=FULL, and go to FETCH.
  - Else if the FIFO is non-empty, pop the head entry, set mode=SINGLE, and go to FETCH.
  - Else stay in IDLE.
  - Full redraw has priority over the FIFO.
- FETCH: drive map_addr; go to WAIT_RAM.
- WAIT_RAM: register map_data into draw_sprite; load draw_x and draw_y; go to GO.
- GO: draw_go=1 for this one cycle; load hold counter with SLOT_CYCLES-2; go to HOLD.
- HOLD: decrement the counter; at 0, leave HOLD.
  - FULL mode: advance col. On wrap (col==COLS-1), col=0 and row++.
  - After the last tile (col==COLS-1, row==ROWS-1), return to IDLE with frame_done=1 for 1 cycle.
  - Otherwise return to FETCH.
  - SINGLE mode: return to IDLE.
- full_start handling:
  - full_start in any state sets a pending flag, cleared when a full redraw begins.
  - full_start arriving during a full redraw restarts it at tile 0 after the current tile's HOLD completes. No frame_done is emitted for the aborted pass.
- FIFO:
  - Queued entries persist across full redraws and are served afterwards.
  - Push and pop in the same cycle are both honoured.
  - upd_ready depends only on the current full flag.
- Out-of-range update (upd_col>=COLS or upd_row>=ROWS): accepted, popped, discarded without any draw_go. Cost: 1 cycle in IDLE.
- Arithmetic:
  - map_addr 9 bits; max 299.
  - draw_x = {col,3'b0} truncated to 8 bits; max 152.
  - draw_y = {row,3'b0} truncated to 7 bits; max 112.

## Timing
- Reset values:
  - state IDLE; draw_go, frame_done, busy = 0.
  - draw_x, draw_y, draw_sprite, map_addr = 0.
  - FIFO empty, so upd_ready=1.
  - Full-redraw pending flag = 0.
- Latency:
  - full_start at edge N: busy=1 at N+1 (FETCH); first draw_go at N+3.
  - Tile period is SLOT_CYCLES+2 = 68 cycles; draw_go pulses are 68 cycles apart within a frame.
  - Full frame = 300*68 = 20400 cycles from FETCH entry to frame_done.
- Drawer compatibility: draw_x, draw_y and draw_sprite are stable from the GO cycle through the last HOLD cycle. This covers the drawer's go-high cycle, its load cycle, and all 64 plot cycles.
- draw_go is never high on two consecutive cycles.
- Reset mid-operation:
  - Takes effect at the next edge: draw_go=0, state IDLE, FIFO flushed, pending cleared.
  - No frame_done is emitted.

## Test plan
- Reset, then a single full_start pulse:
  - Exactly 300 draw_go pulses, each 68 cycles apart.
  - First draw at (0,0); 21st draw at (0,8); last draw at (152,112) with map_addr 299.
  - draw_sprite equals the RAM model contents for each tile.
  - One frame_done pulse, then busy=0.
- Push update (col 3, row 2) while idle, RAM[43]=5:
  - map_addr=43 issued.
  - draw_go 3 cycles after push with x=24, y=16, sprite=5.
  - Back to IDLE after 68 cycles; no frame_done.
- Push 5 updates back-to-back while a full redraw runs:
  - upd_ready drops after the 4th push; the 5th is not accepted.
  - The 4 accepted updates are drawn in order after frame_done.
- full_start at tile 100 of a redraw:
  - Tile 100 completes its 68 cycles, then drawing restarts at (0,0).
  - Only one frame_done, after 300 further tiles.
- Update with col=25, row=3: accepted, no draw_go, FIFO empties, busy returns low.
- resetn low for 1 cycle in the middle of a HOLD with 2 FIFO entries queued:
  - All outputs at reset values next cycle; upd_ready=1.
  - No draw_go until a new request arrives.

Source files
------------

// File: rtl/board_draw_sequencer.sv
// -----------------------------------------------------------------------------
// board_draw_sequencer
//
// Purpose:
//   Walks the level tile map and issues one sprite-draw request per tile to the
//   8x8 sprite drawer. Each request holds x/y/sprite stable for a fixed slot so
//   the drawer's 64-pixel plot finishes before the next request. A full-board
//   redraw is requested by a pulse. Single-tile redraws are queued in a small
//   FIFO and served whenever no full redraw is pending.
//
// Ports:
//   clk             clock
//   resetn          synchronous, active-low reset
//   i_full_start    one-cycle pulse requesting a whole-board redraw
//   i_upd_valid     single-tile update request
//   i_upd_col       tile column of the update (5 bits)
//   i_upd_row       tile row of the update (4 bits)
//   o_upd_ready     update FIFO not full
//   o_map_addr      tile-map RAM read address = row*COLS + col
//   i_map_data      sprite id from tile-map RAM (1-cycle read latency)
//   o_draw_x        sprite anchor x = col*8
//   o_draw_y        sprite anchor y = row*8
//   o_draw_sprite   sprite id for the drawer
//   o_draw_go       one-cycle go pulse to the drawer
//   o_busy          high whenever the sequencer is not idle
//   o_frame_done    one-cycle pulse when a full redraw finishes
//   o_dbg_state     current FSM state (debug visibility)
//
// Handshake: an update entry is transferred on a clock edge where
// i_upd_valid && o_upd_ready. o_upd_ready depends only on the FIFO full flag,
// never on i_upd_valid, so a pop in the same cycle does not free a slot early.
// -----------------------------------------------------------------------------
module board_draw_sequencer #(
    parameter int COLS        = 20,
    parameter int ROWS        = 15,
    parameter int SLOT_CYCLES = 66,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_full_start,
    input  logic       i_upd_valid,
    input  logic [4:0] i_upd_col,
    input  logic [3:0] i_upd_row,
    output logic       o_upd_ready,
    output logic [8:0] o_map_addr,
    input  logic [2:0] i_map_data,
    output logic [7:0] o_draw_x,
    output logic [6:0] o_draw_y,
    output logic [2:0] o_draw_sprite,
    output logic       o_draw_go,
    output logic       o_busy,
    output logic       o_frame_done,
    output logic [2:0] o_dbg_state
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_WAIT_RAM = 3'd2;
    localparam logic [2:0] S_GO       = 3'd3;
    localparam logic [2:0] S_HOLD     = 3'd4;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(SLOT_CYCLES);

    localparam logic [4:0]       LAST_COL  = 5'(COLS - 1);
    localparam logic [3:0]       LAST_ROW  = 4'(ROWS - 1);
    localparam logic [8:0]       COLS_9    = 9'(COLS);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(SLOT_CYCLES - 2);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    logic [2:0]       r_state;
    logic             r_mode_full;
    logic             r_pending;
    logic [4:0]       r_col;
    logic [3:0]       r_row;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_draw_x;
    logic [6:0]       r_draw_y;
    logic [2:0]       r_draw_sprite;
    logic             r_frame_done;

    // FIFO entries are packed {row, col}
    logic [8:0]       r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;
    logic [8:0] w_head;
    logic [4:0] w_head_col;
    logic [3:0] w_head_row;
    logic       w_head_ok;
    logic       w_hold_end;
    logic       w_full_begin;

    assign w_full     = (r_count == FIFO_FULL);
    assign w_empty    = (r_count == '0);
    assign w_push     = i_upd_valid && !w_full;
    // The FIFO is only served from IDLE when no full redraw is waiting
    assign w_pop      = (r_state == S_IDLE) && !r_pending && !w_empty;
    assign w_head     = r_fifo_mem[r_rd_ptr];
    assign w_head_col = w_head[4:0];
    assign w_head_row = w_head[8:5];
    assign w_head_ok  = (w_head_col <= LAST_COL) && (w_head_row <= LAST_ROW);
    assign w_hold_end = (r_state == S_HOLD) && (r_cnt == '0);

    // A full redraw "begins" either from IDLE or as a restart at the end of a
    // tile slot of a running full redraw; both consume the pending flag.
    assign w_full_begin = r_pending &&
                          ((r_state == S_IDLE) || (w_hold_end && r_mode_full));

    // FIFO storage: no reset needed, occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= {i_upd_row, i_upd_col};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_mode_full   <= 1'b0;
            r_pending     <= 1'b0;
            r_col         <= '0;
            r_row         <= '0;
            r_cnt         <= '0;
            r_draw_x      <= '0;
            r_draw_y      <= '0;
            r_draw_sprite <= '0;
            r_frame_done  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            // A new pulse on the same cycle a redraw begins stays pending
            r_pending    <= (r_pending && !w_full_begin) || i_full_start;

            case (r_state)
                S_IDLE: begin
                    if (r_pending) begin
                        r_col       <= '0;
                        r_row       <= '0;
                        r_mode_full <= 1'b1;
                        r_state     <= S_FETCH;
                    end else if (!w_empty) begin
                        // Out-of-range entries are popped and dropped here
                        if (w_head_ok) begin
                            r_col       <= w_head_col;
                            r_row       <= w_head_row;
                            r_mode_full <= 1'b0;
                            r_state     <= S_FETCH;
                        end
                    end
                end

                S_FETCH: begin
                    r_state <= S_WAIT_RAM;
                end

                S_WAIT_RAM: begin
                    r_draw_sprite <= i_map_data;
                    r_draw_x      <= {r_col, 3'b000};
                    r_draw_y      <= {r_row, 3'b000};
                    r_state       <= S_GO;
                end

                S_GO: begin
                    r_cnt   <= HOLD_LOAD;
                    r_state <= S_HOLD;
                end

                S_HOLD: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_mode_full) begin
                        if (r_pending) begin
                            // Abort the pass and restart at tile 0, no frame_done
                            r_col   <= '0;
                            r_row   <= '0;
                            r_state <= S_FETCH;
                        end else if (r_col == LAST_COL) begin
                            if (r_row == LAST_ROW) begin
                                r_frame_done <= 1'b1;
                                r_state      <= S_IDLE;
                            end else begin
                                r_col   <= '0;
                                r_row   <= r_row + 1'b1;
                                r_state <= S_FETCH;
                            end
                        end else begin
                            r_col   <= r_col + 1'b1;
                            r_state <= S_FETCH;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Address is derived from the tile registers so it is valid throughout
    // FETCH, which is the cycle the synchronous RAM samples it.
    assign o_map_addr    = ({5'b0, r_row} * COLS_9) + {4'b0, r_col};
    assign o_upd_ready   = !w_full;
    assign o_draw_x      = r_draw_x;
    assign o_draw_y      = r_draw_y;
    assign o_draw_sprite = r_draw_sprite;
    assign o_draw_go     = (r_state == S_GO);
    assign o_busy        = (r_state != S_IDLE);
    assign o_frame_done  = r_frame_done;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_board_draw_sequencer.sv
// -----------------------------------------------------------------------------
// tb_board_draw_sequencer
//
// Directed bench for board_draw_sequencer: a table of single-tile updates with
// hand-computed draw results, plus hand-written sequences for a full frame,
// FIFO back-pressure during a frame, a mid-frame restart and a mid-HOLD reset.
// A synchronous tile-map RAM model answers map_addr with one cycle of latency.
// -----------------------------------------------------------------------------
module tb_board_draw_sequencer;

    logic       clk = 1'b0;
    logic       resetn;
    logic       full_start;
    logic       upd_valid;
    logic [4:0] upd_col;
    logic [3:0] upd_row;
    logic       upd_ready;
    logic [8:0] map_addr;
    logic [2:0] map_data;
    logic [7:0] draw_x;
    logic [6:0] draw_y;
    logic [2:0] draw_sprite;
    logic       draw_go;
    logic       busy;
    logic       frame_done;
    logic [2:0] dbg_state;

    board_draw_sequencer #(
        .COLS(20), .ROWS(15), .SLOT_CYCLES(66), .FIFO_DEPTH(4)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .i_full_start  (full_start),
        .i_upd_valid   (upd_valid),
        .i_upd_col     (upd_col),
        .i_upd_row     (upd_row),
        .o_upd_ready   (upd_ready),
        .o_map_addr    (map_addr),
        .i_map_data    (map_data),
        .o_draw_x      (draw_x),
        .o_draw_y      (draw_y),
        .o_draw_sprite (draw_sprite),
        .o_draw_go     (draw_go),
        .o_busy        (busy),
        .o_frame_done  (frame_done),
        .o_dbg_state   (dbg_state)
    );

    // ---------------- clock / RAM model ----------------
    always #5 clk = ~clk;

    logic [2:0] ram [512];
    always @(posedge clk) map_data <= ram[map_addr];

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int fd_count = 0;
    int fd_cyc   = 0;
    logic fd_busy = 1'b0;
    logic prev_go = 1'b0;

    // draw record packed {addr[8:0], x[7:0], y[6:0], sprite[2:0]}
    logic [26:0] exp_q[$];
    logic [26:0] act_q[$];
    int          go_cyc_q[$];

    typedef struct {
        logic [4:0] col;
        logic [3:0] row;
        logic       exp_draw;
        logic [8:0] exp_addr;
        logic [7:0] exp_x;
        logic [6:0] exp_y;
        logic [2:0] exp_spr;
        int         exp_busy;
    } upd_vec_t;

    upd_vec_t vecs[8];

    function automatic logic [26:0] pack(input logic [8:0] a, input logic [7:0] x,
                                         input logic [6:0] y, input logic [2:0] s);
        return {a, x, y, s};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: advance to just after the edge and log what the DUT shows
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (draw_go) begin
            check("go_not_back_to_back", {31'b0, prev_go}, 32'd0);
            act_q.push_back(pack(map_addr, draw_x, draw_y, draw_sprite));
            go_cyc_q.push_back(cyc);
        end
        if (frame_done) begin
            fd_count++;
            fd_cyc  = cyc;
            fd_busy = busy;
        end
        prev_go = draw_go;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_logs();
        exp_q.delete();
        act_q.delete();
        go_cyc_q.delete();
    endtask

    task automatic pulse_full();
        full_start = 1'b1;
        tick();
        full_start = 1'b0;
    endtask

    task automatic wait_fd(input int target, input int budget, input string name);
        int n = 0;
        while (fd_count < target && n < budget) begin
            tick();
            n++;
        end
        check(name, fd_count, target);
    endtask

    task automatic wait_gos(input int target, input int budget, input string name);
        int n = 0;
        while (act_q.size() < target && n < budget) begin
            tick();
            n++;
        end
        check(name, act_q.size() >= target, 1);
    endtask

    task automatic check_draws(input string name);
        check({name, "_count"}, act_q.size(), exp_q.size());
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (act_q[i] !== exp_q[i]) begin
                n_fails++;
                $display("FAIL %s[%0d]: got addr=%0d x=%0d y=%0d spr=%0d expected addr=%0d x=%0d y=%0d spr=%0d",
                         name, i, act_q[i][26:18], act_q[i][17:10], act_q[i][9:3], act_q[i][2:0],
                         exp_q[i][26:18], exp_q[i][17:10], exp_q[i][9:3], exp_q[i][2:0]);
            end
        end
    endtask

    task automatic check_spacing(input string name);
        for (int i = 1; i < go_cyc_q.size(); i++) begin
            check($sformatf("%s_gap%0d", name, i), go_cyc_q[i] - go_cyc_q[i-1], 68);
        end
    endtask

    task automatic exp_frame(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            exp_q.push_back(pack(9'(i), 8'((i % 20) * 8), 7'((i / 20) * 8), ram[i]));
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int fd0;
        int n_edge;
        int fetch_cyc;
        int push_cyc;
        int busy_cnt;
        int go_before;

        for (int i = 0; i < 512; i++) ram[i] = (i < 300) ? 3'((i * 5 + i / 20) % 8) : 3'd0;
        ram[43] = 3'd5;

        // col, row, draw?, addr, x, y, sprite, busy cycles
        vecs[0] = '{5'd3,  4'd2,  1'b1, 9'd43,  8'd24,  7'd16,  3'd5, 68};
        vecs[1] = '{5'd0,  4'd0,  1'b1, 9'd0,   8'd0,   7'd0,   3'd0, 68};
        vecs[2] = '{5'd19, 4'd14, 1'b1, 9'd299, 8'd152, 7'd112, 3'd5, 68};
        vecs[3] = '{5'd25, 4'd3,  1'b0, 9'd0,   8'd0,   7'd0,   3'd0, 0};
        vecs[4] = '{5'd19, 4'd0,  1'b1, 9'd19,  8'd152, 7'd0,   3'd7, 68};
        vecs[5] = '{5'd5,  4'd15, 1'b0, 9'd0,   8'd0,   7'd0,   3'd0, 0};
        vecs[6] = '{5'd0,  4'd14, 1'b1, 9'd280, 8'd0,   7'd112, 3'd6, 68};
        vecs[7] = '{5'd31, 4'd15, 1'b0, 9'd0,   8'd0,   7'd0,   3'd0, 0};

        resetn = 1'b0; full_start = 1'b0; upd_valid = 1'b0; upd_col = '0; upd_row = '0;

        // ---- reset state ----
        ticks(3);
        check("rst_draw_go", draw_go, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_busy", busy, 0);
        check("rst_upd_ready", upd_ready, 1);
        check("rst_map_addr", map_addr, 0);
        check("rst_draw_x", draw_x, 0);
        check("rst_draw_y", draw_y, 0);
        check("rst_draw_sprite", draw_sprite, 0);
        check("rst_state", dbg_state, 0);
        resetn = 1'b1;
        ticks(2);

        // ---- single full frame ----
        clear_logs();
        fd0 = fd_count;
        pulse_full();
        n_edge = cyc;
        check("full_busy_at_N", busy, 0);
        tick();
        check("full_busy_at_N1", busy, 1);
        fetch_cyc = cyc;
        wait_fd(fd0 + 1, 21000, "full_frame_done_seen");
        exp_frame(0, 299);
        check_draws("full");
        check_spacing("full");
        if (go_cyc_q.size() > 0) check("full_first_go_latency", go_cyc_q[0] - n_edge, 3);
        if (act_q.size() == 300) begin
            check("full_first_draw", act_q[0], pack(9'd0, 8'd0, 7'd0, ram[0]));
            check("full_21st_draw", act_q[20], pack(9'd20, 8'd0, 7'd8, ram[20]));
            check("full_last_draw", act_q[299], pack(9'd299, 8'd152, 7'd112, ram[299]));
        end
        check("full_frame_length", fd_cyc - fetch_cyc, 20400);
        check("full_busy_at_frame_done", fd_busy, 0);
        ticks(10);
        check("full_single_frame_done", fd_count, fd0 + 1);
        check("full_busy_after", busy, 0);

        // ---- table-driven single-tile updates ----
        foreach (vecs[v]) begin
            clear_logs();
            fd0 = fd_count;
            upd_valid = 1'b1; upd_col = vecs[v].col; upd_row = vecs[v].row;
            check($sformatf("vec%0d_ready", v), upd_ready, 1);
            tick();
            upd_valid = 1'b0;
            push_cyc = cyc;
            busy_cnt = 0;
            for (int i = 0; i < 80; i++) begin
                tick();
                if (busy) busy_cnt++;
            end
            if (vecs[v].exp_draw)
                exp_q.push_back(pack(vecs[v].exp_addr, vecs[v].exp_x, vecs[v].exp_y, vecs[v].exp_spr));
            check_draws($sformatf("vec%0d", v));
            if (vecs[v].exp_draw && go_cyc_q.size() > 0)
                check($sformatf("vec%0d_go_latency", v), go_cyc_q[0] - push_cyc, 3);
            check($sformatf("vec%0d_busy_cycles", v), busy_cnt, vecs[v].exp_busy);
            check($sformatf("vec%0d_no_frame_done", v), fd_count, fd0);
            check($sformatf("vec%0d_ready_after", v), upd_ready, 1);
        end

        // ---- 5 updates pushed during a full frame ----
        clear_logs();
        fd0 = fd_count;
        pulse_full();
        ticks(10);
        for (int k = 0; k < 5; k++) begin
            upd_valid = 1'b1; upd_col = 5'(k + 1); upd_row = 4'(k + 1);
            check($sformatf("bp_ready_before_push%0d", k), upd_ready, (k < 4) ? 1 : 0);
            tick();
        end
        upd_valid = 1'b0;
        tick();
        check("bp_ready_while_full", upd_ready, 0);
        wait_fd(fd0 + 1, 21000, "bp_frame_done_seen");
        ticks(4 * 68 + 20);
        exp_frame(0, 299);
        for (int k = 1; k <= 4; k++) exp_q.push_back(pack(9'(21 * k), 8'(8 * k), 7'(8 * k), ram[21 * k]));
        check_draws("bp");
        if (go_cyc_q.size() > 300) check("bp_first_update_after_frame", go_cyc_q[300] - fd_cyc, 3);
        check("bp_ready_drained", upd_ready, 1);
        check("bp_busy_after", busy, 0);
        check("bp_one_frame_done", fd_count, fd0 + 1);

        // ---- restart at tile 100 ----
        clear_logs();
        fd0 = fd_count;
        pulse_full();
        wait_gos(101, 101 * 68 + 100, "rs_reached_tile100");
        ticks(5);
        pulse_full();
        wait_fd(fd0 + 1, 300 * 68 + 300, "rs_frame_done_seen");
        ticks(10);
        exp_frame(0, 100);
        exp_frame(0, 299);
        check_draws("rs");
        check_spacing("rs");
        if (go_cyc_q.size() > 101) check("rs_frame_length", fd_cyc - go_cyc_q[101], 20398);
        check("rs_one_frame_done", fd_count, fd0 + 1);
        check("rs_busy_after", busy, 0);

        // ---- reset during HOLD with 2 queued entries and a pending redraw ----
        clear_logs();
        fd0 = fd_count;
        pulse_full();
        wait_gos(1, 100, "mr_first_go");
        ticks(10);
        upd_valid = 1'b1; upd_col = 5'd4; upd_row = 4'd4;
        tick();
        upd_col = 5'd6; upd_row = 4'd2;
        tick();
        upd_valid = 1'b0;
        pulse_full();
        check("mr_busy_before_reset", busy, 1);
        resetn = 1'b0;
        tick();
        check("mr_draw_go", draw_go, 0);
        check("mr_frame_done", frame_done, 0);
        check("mr_busy", busy, 0);
        check("mr_upd_ready", upd_ready, 1);
        check("mr_map_addr", map_addr, 0);
        check("mr_draw_x", draw_x, 0);
        check("mr_draw_y", draw_y, 0);
        check("mr_draw_sprite", draw_sprite, 0);
        resetn = 1'b1;
        go_before = act_q.size();
        busy_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (busy) busy_cnt++;
        end
        check("mr_no_go_after_reset", act_q.size(), go_before);
        check("mr_idle_after_reset", busy_cnt, 0);
        check("mr_no_frame_done", fd_count, fd0);
        // A fresh request is served normally afterwards
        clear_logs();
        upd_valid = 1'b1; upd_col = 5'd2; upd_row = 4'd1;
        tick();
        upd_valid = 1'b0;
        ticks(80);
        exp_q.push_back(pack(9'd22, 8'd16, 7'd8, 3'd7));
        check_draws("mr_new_request");
        check("mr_busy_end", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
